// File: rtl/ctrl_seq.sv
// Control sequencer for the 8-bit CPU: six-state one-hot ring (fetch T1-T3, execute T4-T6)
// with a combinational strobe decode of (t_state, opcode), gated by en, !halted and !rst.
module ctrl_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] opcode,
   output logic       pc_inc,
   output logic       pc_out,
   output logic       mar_in,
   output logic       ram_out,
   output logic       ram_in,
   output logic       ir_in,
   output logic       ir_out,
   output logic       a_in,
   output logic       a_out,
   output logic       b_in,
   output logic       alu_out,
   output logic       alu_sub,
   output logic       out_in,
   output logic [5:0] t_state,
   output logic       halted
);

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_STA = 4'b0011;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_state_e;

   t_state_e state;

   assign t_state = state;

   // Ring advance; HLT freezes the ring at T4 until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= T1;
         halted <= 1'b0;
      end else if (en && !halted) begin
         if (state == T4 && opcode == OP_HLT) begin
            halted <= 1'b1;
         end else begin
            case (state)
               T1:      state <= T2;
               T2:      state <= T3;
               T3:      state <= T4;
               T4:      state <= T5;
               T5:      state <= T6;
               T6:      state <= T1;
               default: state <= T1;
            endcase
         end
      end else begin
         state  <= state;
         halted <= halted;
      end
   end

   // Strobe decode; everything is forced low whenever the sequencer is not running
   always_comb begin
      pc_inc  = 1'b0;
      pc_out  = 1'b0;
      mar_in  = 1'b0;
      ram_out = 1'b0;
      ram_in  = 1'b0;
      ir_in   = 1'b0;
      ir_out  = 1'b0;
      a_in    = 1'b0;
      a_out   = 1'b0;
      b_in    = 1'b0;
      alu_out = 1'b0;
      alu_sub = 1'b0;
      out_in  = 1'b0;
      if (!rst && en && !halted) begin
         case (state)
            T1: begin
               pc_out = 1'b1;
               mar_in = 1'b1;
            end
            T2: pc_inc = 1'b1;
            T3: begin
               ram_out = 1'b1;
               ir_in   = 1'b1;
            end
            T4: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_out = 1'b1;
                     mar_in = 1'b1;
                  end
                  OP_OUT: begin
                     a_out  = 1'b1;
                     out_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            T5: begin
               case (opcode)
                  OP_LDA: begin
                     ram_out = 1'b1;
                     a_in    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_out = 1'b1;
                     b_in    = 1'b1;
                  end
                  OP_STA: begin
                     a_out  = 1'b1;
                     ram_in = 1'b1;
                  end
                  default: ;
               endcase
            end
            T6: begin
               case (opcode)
                  OP_ADD: begin
                     alu_out = 1'b1;
                     a_in    = 1'b1;
                  end
                  OP_SUB: begin
                     alu_out = 1'b1;
                     a_in    = 1'b1;
                     alu_sub = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end else begin
         pc_inc = 1'b0;
      end
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed self-checking bench for ctrl_seq: per-opcode strobe tables, HLT, en pause,
// mid-instruction reset and a randomized invariant sweep.
module tb_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [3:0] opcode = 4'b0000;
   logic       pc_inc, pc_out, mar_in, ram_out, ram_in, ir_in, ir_out;
   logic       a_in, a_out, b_in, alu_out, alu_sub, out_in;
   logic [5:0] t_state;
   logic       halted;

   int tests = 0;
   int fails = 0;

   ctrl_seq dut (
      .clk(clk), .rst(rst), .en(en), .opcode(opcode),
      .pc_inc(pc_inc), .pc_out(pc_out), .mar_in(mar_in), .ram_out(ram_out),
      .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out), .a_in(a_in), .a_out(a_out),
      .b_in(b_in), .alu_out(alu_out), .alu_sub(alu_sub), .out_in(out_in),
      .t_state(t_state), .halted(halted)
   );

   always #5 clk = ~clk;

   // bit order: pc_inc pc_out mar_in ram_out ram_in ir_in ir_out a_in a_out b_in alu_out alu_sub out_in
   wire [12:0] strobes = {pc_inc, pc_out, mar_in, ram_out, ram_in, ir_in, ir_out,
                          a_in, a_out, b_in, alu_out, alu_sub, out_in};

   localparam logic [12:0] S_NONE = 13'h0000;
   localparam logic [12:0] S_T1   = 13'h0C00;
   localparam logic [12:0] S_T2   = 13'h1000;
   localparam logic [12:0] S_T3   = 13'h0280;
   localparam logic [12:0] S_IRMA = 13'h0440;
   localparam logic [12:0] S_LDA5 = 13'h0220;
   localparam logic [12:0] S_ADD5 = 13'h0208;
   localparam logic [12:0] S_ADD6 = 13'h0024;
   localparam logic [12:0] S_SUB6 = 13'h0026;
   localparam logic [12:0] S_STA5 = 13'h0110;
   localparam logic [12:0] S_OUT4 = 13'h0011;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b1;
      step();
      step();
      #2;
      tests++;
      if (t_state !== 6'b000001) begin
         fails++;
         $display("FAIL reset_tstate: got %b want 000001", t_state);
      end
      tests++;
      if (halted !== 1'b0) begin
         fails++;
         $display("FAIL reset_halted: got %b want 0", halted);
      end
      tests++;
      if (strobes !== S_NONE) begin
         fails++;
         $display("FAIL reset_strobes: got %h want %h", strobes, S_NONE);
      end
      rst = 1'b0;
   endtask

   task automatic test_instr(input string name, input logic [3:0] op,
                             input logic [12:0] e4, input logic [12:0] e5, input logic [12:0] e6);
      logic [12:0] exp [6];
      exp = '{S_T1, S_T2, S_T3, e4, e5, e6};
      en = 1'b1;
      do_reset();
      opcode = ~op;
      for (int i = 0; i < 6; i++) begin
         if (i == 3) opcode = op;
         #2;
         tests++;
         if (t_state !== (6'b000001 << i)) begin
            fails++;
            $display("FAIL %s_tstate_T%0d: got %b want %b", name, i + 1, t_state, 6'b000001 << i);
         end
         tests++;
         if (strobes !== exp[i]) begin
            fails++;
            $display("FAIL %s_strobes_T%0d: got %h want %h", name, i + 1, strobes, exp[i]);
         end
         step();
      end
      #2;
      tests++;
      if (t_state !== 6'b000001) begin
         fails++;
         $display("FAIL %s_wrap: got %b want 000001", name, t_state);
      end
   endtask

   task automatic test_hlt();
      en = 1'b1;
      do_reset();
      opcode = 4'b1111;
      for (int i = 0; i < 4; i++) step();
      #2;
      tests++;
      if (halted !== 1'b1 || t_state !== 6'b001000) begin
         fails++;
         $display("FAIL hlt_entry: got halted=%b t=%b want halted=1 t=001000", halted, t_state);
      end
      for (int i = 0; i < 12; i++) begin
         opcode = 4'(i);
         step();
         tests++;
         if (t_state !== 6'b001000 || strobes !== S_NONE || halted !== 1'b1) begin
            fails++;
            $display("FAIL hlt_hold_%0d: got t=%b s=%h h=%b want t=001000 s=0000 h=1",
                     i, t_state, strobes, halted);
         end
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #2;
      tests++;
      if (t_state !== 6'b000001 || halted !== 1'b0) begin
         fails++;
         $display("FAIL hlt_clear: got t=%b h=%b want t=000001 h=0", t_state, halted);
      end
   endtask

   task automatic test_enable_pause();
      en = 1'b1;
      opcode = 4'b0000;
      do_reset();
      step();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         tests++;
         if (pc_inc !== 1'b0 || t_state !== 6'b000010) begin
            fails++;
            $display("FAIL pause_%0d: got pc_inc=%b t=%b want pc_inc=0 t=000010", i, pc_inc, t_state);
         end
         step();
      end
      en = 1'b1;
      #2;
      tests++;
      if (strobes !== S_T2 || t_state !== 6'b000010) begin
         fails++;
         $display("FAIL resume: got s=%h t=%b want s=%h t=000010", strobes, t_state, S_T2);
      end
      step();
      #2;
      tests++;
      if (pc_inc !== 1'b0 || t_state !== 6'b000100) begin
         fails++;
         $display("FAIL resume_once: got pc_inc=%b t=%b want pc_inc=0 t=000100", pc_inc, t_state);
      end
   endtask

   task automatic test_rst_mid();
      en = 1'b1;
      opcode = 4'b0011;
      do_reset();
      for (int i = 0; i < 4; i++) step();
      #2;
      tests++;
      if (strobes !== S_STA5) begin
         fails++;
         $display("FAIL sta_t5: got %h want %h", strobes, S_STA5);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (ram_in !== 1'b0 || strobes !== S_NONE) begin
         fails++;
         $display("FAIL rst_gate: got ram_in=%b s=%h want 0", ram_in, strobes);
      end
      step();
      rst = 1'b0;
      #2;
      tests++;
      if (t_state !== 6'b000001 || strobes !== S_T1) begin
         fails++;
         $display("FAIL rst_mid: got t=%b s=%h want t=000001 s=%h", t_state, strobes, S_T1);
      end
   endtask

   task automatic test_random();
      en = 1'b1;
      do_reset();
      for (int i = 0; i < 1000; i++) begin
         opcode = 4'($urandom_range(15));
         en     = ($urandom_range(7) != 0);
         rst    = halted ? ($urandom_range(3) == 0) : 1'b0;
         #2;
         tests++;
         if (!$onehot(t_state)) begin
            fails++;
            $display("FAIL rand_onehot_%0d: got %b want one-hot", i, t_state);
         end
         tests++;
         if ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
            fails++;
            $display("FAIL rand_bus_%0d: got s=%h want at most one driver", i, strobes);
         end
         if (!en) begin
            tests++;
            if (strobes !== S_NONE) begin
               fails++;
               $display("FAIL rand_en_gate_%0d: got %h want 0000", i, strobes);
            end
         end
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_instr("lda", 4'b0000, S_IRMA, S_LDA5, S_NONE);
      test_instr("add", 4'b0001, S_IRMA, S_ADD5, S_ADD6);
      test_instr("sub", 4'b0010, S_IRMA, S_ADD5, S_SUB6);
      test_instr("sta", 4'b0011, S_IRMA, S_STA5, S_NONE);
      test_instr("out", 4'b1110, S_OUT4, S_NONE, S_NONE);
      test_instr("nop", 4'b0101, S_NONE, S_NONE, S_NONE);
      test_hlt();
      test_enable_pause();
      test_rst_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
